// File: rtl/pipe_hazard_ctrl.sv
// Hazard and pipeline-control unit for a 5-stage pipeline (IF, ID, EX, MEM, WB).
// Keeps a shadow copy of per-stage control state and derives stall, bubble,
// flush and forwarding selects from it in the same cycle.
module pipe_hazard_ctrl #(
  parameter int RA_W       = 2,
  parameter int JUMP_STAGE = 3,  // 2 = EX, 3 = MEM
  parameter int FWD_EN     = 1,
  parameter int CNT_W      = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [RA_W-1:0] id_rs_a,
  input  logic            id_rs_a_used,
  input  logic [RA_W-1:0] id_rs_b,
  input  logic            id_rs_b_used,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_wr,
  input  logic            id_rm,
  input  logic            jump_taken,
  output logic            pc_en,
  output logic            ifid_en,
  output logic            idex_bubble,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic            flush_exmem,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic [3:0]      stage_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic            wr;
    logic            rm;
    logic [RA_W-1:0] rs_a;
    logic            rs_a_used;
    logic [RA_W-1:0] rs_b;
    logic            rs_b_used;
  } slot_t;

  logic  id_valid;
  slot_t id_slot, ex_slot, mem_slot, wb_slot;
  logic  hit_ex, hit_mem, hit_wb;
  logic  stall_req, jump_ok, jump, stall;

  // Producer in slot s writes register r.
  function automatic logic match(input slot_t s, input logic [RA_W-1:0] r);
    return s.valid & s.wr & (s.rd == r);
  endfunction

  // Forwarding select for one EX operand; MEM wins over WB as the younger producer.
  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] r, input logic used,
                                         input slot_t m, input slot_t w);
    logic [1:0] sel;
    sel = 2'b00;
    if (used) begin
      if (match(m, r) && !m.rm) sel = 2'b01;
      else if (match(w, r))     sel = 2'b10;
    end
    return sel;
  endfunction

  // Only the valid bit of ID is registered; its fields come straight from decode.
  always_comb begin
    id_slot = '{valid: id_valid, rd: id_rd, wr: id_wr, rm: id_rm,
                rs_a: id_rs_a, rs_a_used: id_rs_a_used,
                rs_b: id_rs_b, rs_b_used: id_rs_b_used};
  end

  // RAW detection for the ID instruction, then jump-over-stall arbitration.
  always_comb begin
    hit_ex  = (id_rs_a_used & match(ex_slot,  id_rs_a)) | (id_rs_b_used & match(ex_slot,  id_rs_b));
    hit_mem = (id_rs_a_used & match(mem_slot, id_rs_a)) | (id_rs_b_used & match(mem_slot, id_rs_b));
    hit_wb  = (id_rs_a_used & match(wb_slot,  id_rs_a)) | (id_rs_b_used & match(wb_slot,  id_rs_b));
    if (FWD_EN != 0) stall_req = hit_ex & ex_slot.rm;
    else             stall_req = hit_ex | hit_mem | hit_wb;
    jump_ok = (JUMP_STAGE == 3) ? mem_slot.valid : ex_slot.valid;
    jump    = jump_taken & jump_ok;
    stall   = stall_req & ~jump;
  end

  // Control outputs; everything is held quiet while reset is high.
  always_comb begin
    pc_en       = ~reset & ~stall;
    ifid_en     = ~reset & ~stall;
    idex_bubble = ~reset & stall;
    flush_ifid  = ~reset & jump;
    flush_idex  = ~reset & jump;
    flush_exmem = ~reset & jump & (JUMP_STAGE == 3);
    fwd_a       = 2'b00;
    fwd_b       = 2'b00;
    if (FWD_EN != 0 && !reset) begin
      fwd_a = fwd_sel(ex_slot.rs_a, ex_slot.rs_a_used, mem_slot, wb_slot);
      fwd_b = fwd_sel(ex_slot.rs_b, ex_slot.rs_b_used, mem_slot, wb_slot);
    end
    stage_valid = {wb_slot.valid, mem_slot.valid, ex_slot.valid, id_valid};
  end

  // Shadow pipeline advance: jump squashes younger slots, stall inserts a bubble into EX.
  always_ff @(posedge clock) begin
    if (reset) begin
      id_valid <= 1'b0;
      ex_slot  <= '0;
      mem_slot <= '0;
      wb_slot  <= '0;
    end else if (jump) begin
      id_valid <= 1'b0;
      ex_slot  <= '0;
      mem_slot <= (JUMP_STAGE == 3) ? '0 : ex_slot;
      wb_slot  <= mem_slot;
    end else if (stall) begin
      ex_slot  <= '0;
      mem_slot <= ex_slot;
      wb_slot  <= mem_slot;
    end else begin
      id_valid <= 1'b1;
      ex_slot  <= id_slot;
      mem_slot <= ex_slot;
      wb_slot  <= mem_slot;
    end
  end

  // Saturating debug counters for stall and jump cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (jump  && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  // Source fields of MEM/WB and WB.rm are kept for debug visibility only.
  logic unused_fields;
  assign unused_fields = ^{mem_slot.rs_a, mem_slot.rs_a_used, mem_slot.rs_b, mem_slot.rs_b_used,
                           wb_slot.rs_a, wb_slot.rs_a_used, wb_slot.rs_b, wb_slot.rs_b_used,
                           wb_slot.rm};

endmodule
